// File: rtl/verinject_injection_scheduler.sv
// Injection scheduler: drives the shared verinject__injector_state command bus
// that every injector decodes. Holds a small table of (run-cycle, bit-index)
// pairs. A run issues one FIFO-clear command, then replays each bit index on
// the bus for exactly one cycle at its scheduled run-cycle.
module verinject_injection_scheduler #(
  parameter int SLOTS      = 8,
  parameter int SLOTS_LOG2 = 3,
  parameter int CYCLE_W    = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfg_write,
  input  logic [SLOTS_LOG2-1:0] cfg_slot,
  input  logic [CYCLE_W-1:0]    cfg_cycle,
  input  logic [31:0]           cfg_index,
  input  logic [SLOTS_LOG2:0]   cfg_count,
  output logic                  cfg_error,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear_faults,
  output logic [31:0]           verinject__injector_state,
  output logic                  busy,
  output logic                  done,
  output logic [CYCLE_W-1:0]    run_cycle,
  output logic [SLOTS_LOG2:0]   late_count
);

  localparam logic [31:0]         BUS_IDLE  = 32'hFFFF_FFFF;
  localparam logic [31:0]         BUS_CLEAR = 32'hFFFF_FFFE;
  localparam logic [SLOTS_LOG2:0] SLOTS_CNT = (SLOTS_LOG2 + 1)'(SLOTS);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

  state_t                r_state;
  logic [31:0]           r_bus;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_cfg_error;
  logic [CYCLE_W-1:0]    r_run_cycle;
  logic [SLOTS_LOG2:0]   r_late_count;
  logic [SLOTS_LOG2:0]   r_count;  // entries in this run, already capped at SLOTS
  logic [SLOTS_LOG2:0]   r_ptr;    // next entry still to be issued

  logic [CYCLE_W-1:0]    r_tbl_cycle [SLOTS];
  logic [31:0]           r_tbl_index [SLOTS];

  logic [SLOTS_LOG2-1:0] w_ptr_idx;
  logic [CYCLE_W-1:0]    w_cur_cycle;
  logic [31:0]           w_cur_index;
  logic [CYCLE_W-1:0]    w_target_rc;
  logic                  w_pending;
  logic                  w_fire;
  logic                  w_late;
  logic [SLOTS_LOG2:0]   w_count_sat;
  logic                  w_cfg_reject;
  logic                  w_cfg_accept;

  assign w_ptr_idx    = r_ptr[SLOTS_LOG2-1:0];
  assign w_cur_cycle  = r_tbl_cycle[w_ptr_idx];
  assign w_cur_index  = r_tbl_index[w_ptr_idx];
  assign w_pending    = (r_ptr < r_count);
  assign w_count_sat  = (cfg_count > SLOTS_CNT) ? SLOTS_CNT : cfg_count;
  // Writes are refused while a run is in flight, and for indices that would
  // alias the two bus command codes.
  assign w_cfg_reject = cfg_write && (r_busy || (cfg_index >= BUS_CLEAR));
  assign w_cfg_accept = cfg_write && !w_cfg_reject;

  // Run-cycle that the next registered bus value belongs to: the CLEAR cycle
  // is followed by run-cycle 0, every RUN cycle by the following run-cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_target_rc = run_cycle_plus_one(r_run_cycle);
    if (r_state == S_CLEAR) w_target_rc = '0;
  end

  function automatic logic [CYCLE_W-1:0] run_cycle_plus_one(input logic [CYCLE_W-1:0] rc);
    return rc + CYCLE_W'(1);
  endfunction

  // An entry whose cycle has already passed is issued now and counted as late.
  assign w_fire = w_pending && (w_cur_cycle <= w_target_rc);
  assign w_late = (w_cur_cycle != w_target_rc);

  // Schedule table storage.
  // NOTE: the table is plain storage with no reset, so a reset never loses the programmed schedule.
  always_ff @(posedge clock) begin
    if (!reset && w_cfg_accept) begin
      r_tbl_cycle[cfg_slot] <= cfg_cycle;
      r_tbl_index[cfg_slot] <= cfg_index;
    end
  end

  // Control FSM with registered bus and status outputs.
  always_ff @(posedge clock) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (reset) begin
      r_state      <= S_IDLE;
      r_bus        <= BUS_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cfg_error  <= 1'b0;
      r_run_cycle  <= '0;
      r_late_count <= '0;
      r_count      <= '0;
      r_ptr        <= '0;
    end else begin
      r_done      <= 1'b0;
      r_cfg_error <= w_cfg_reject;
      case (r_state)
        S_IDLE: begin
          r_bus <= BUS_IDLE;
          if (start) begin
            r_state      <= S_CLEAR;
            r_bus        <= BUS_CLEAR;
            r_busy       <= 1'b1;
            r_count      <= w_count_sat;
            r_late_count <= '0;
            r_ptr        <= '0;
          end else if (clear_faults) begin
            r_bus <= BUS_CLEAR;
          end
        end
        S_CLEAR, S_RUN: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_bus   <= BUS_IDLE;
            r_busy  <= 1'b0;
          end else begin
            if (r_state == S_CLEAR) r_run_cycle <= '0;
            if (!w_pending) begin
              // Last entry went out this cycle (or there were none to send).
              r_state <= S_DONE;
              r_bus   <= BUS_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_RUN;
              r_run_cycle <= w_target_rc;
              if (w_fire) begin
                r_bus <= w_cur_index;
                r_ptr <= r_ptr + 1'b1;
                if (w_late) r_late_count <= r_late_count + 1'b1;
              end else begin
                r_bus <= BUS_IDLE;
              end
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_bus   <= BUS_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_bus   <= BUS_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign verinject__injector_state = r_bus;
  assign busy                      = r_busy;
  assign done                      = r_done;
  assign cfg_error                 = r_cfg_error;
  assign run_cycle                 = r_run_cycle;
  assign late_count                = r_late_count;

endmodule
